decoder_scan_sequencer: RTL and testbench
=========================================

Name: decoder_scan_sequencer

Overview:
- Upstream driver for the n-bit one-hot decoder: produces the index bus `a` and the `enable` strobe the decoder consumes.
- Steps the index 0..last_idx, holding each value for a programmable dwell time.
- Inserts a blanking gap (`enable` low) between selections so no two decoder outputs are ever active together.
- Supports single-sweep and continuous modes; typical uses are display/row scanning and channel strobing.

Parameters:
- N, 3, index width; must match the decoder's N.
- DWELL_W, 8, width of the dwell-time input and internal dwell counter.
- BLANK, 1, blanking cycles between selections (0 = none; otherwise 1..255).

Ports:
- clk  input  1  clock; all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; sampled in IDLE only
- stop  input  1  abort the sweep; sampled in ACTIVE/BLANK
- mode  input  1  0 = single sweep, 1 = continuous
- dwell  input  DWELL_W  cycles `enable` is held per index; value 0 is treated as 1
- last_idx  input  N  highest index in the sweep
- a  output  N  index to decoder (registered)
- enable  output  1  decoder enable (registered)
- busy  output  1  high in ACTIVE/BLANK
- done  output  1  1-cycle pulse at the end of a single sweep
- wrap  output  1  1-cycle pulse when a continuous sweep restarts at 0

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - a = 0, enable = 0, busy = 0, done = 0, wrap = 0.
  - Dwell and blank counters cleared.
- Outputs are all registered, with no combinational path from inputs to outputs.
- FSM states: IDLE, ACTIVE, BLANK.
- IDLE:
  - `start` = 1 and `stop` = 0 at edge k → ACTIVE.
  - At edge k, latch mode, last_idx, and D = max(dwell, 1); later input changes have no effect until the next start.
  - From edge k+1: a = 0, enable = 1, busy = 1.
  - `start` and `stop` both high in IDLE: stop wins, remain IDLE.
- ACTIVE:
  - `enable` = 1 for exactly D cycles.
  - After the D-th cycle:
    - BLANK > 0 → go to BLANK.
    - BLANK = 0 → advance the index (rule below).
- BLANK:
  - `enable` = 0 and `a` held for exactly BLANK cycles, then advance the index.
- Advance rule:
  - a < latched last_idx → a = a+1, go to ACTIVE.
  - a == last_idx, mode = 0 → IDLE. In that cycle: done = 1, busy = 0, enable = 0, a = 0.
  - a == last_idx, mode = 1 → a = 0, go to ACTIVE. wrap = 1 for the first cycle of the new index 0.
- Timing: with start sampled at edge k, index i is active from edge k+1+i·(D+BLANK). Single-sweep `done` asserts at edge k+1+(last_idx+1)·(D+BLANK).
- last_idx = 0 is legal: only index 0 is scanned. In continuous mode, `wrap` pulses every D+BLANK cycles.
- last_idx = 2^N−1 is legal: the index never overflows, the sequencer returns to 0 explicitly.
- `stop` = 1 sampled in ACTIVE or BLANK:
  - Next edge: IDLE, enable = 0, a = 0, busy = 0.
  - No `done`, no `wrap`.
  - `stop` has priority over a coincident advance, done, or wrap.
- `start` while busy is ignored. `stop` in IDLE is ignored.
- Asynchronous reset mid-sweep behaves exactly as the reset state; no pulse is emitted.
- `done` and `wrap` are never high in the same cycle. Each is exactly 1 cycle wide.
- `enable` never rises in the same cycle that `a` changes value except on entry to an index (a and enable are updated on the same edge). The decoder therefore sees a stable index whenever enable = 1.

Test Plan:
- N=3, BLANK=1, mode=0, dwell=2, last_idx=3, start pulse at edge 0:
  - a=0 with en=1 at edges 1–2; en=0 at edge 3; a=1 with en=1 at edges 4–5; …; a=3 with en=1 at edges 10–11; blank at edge 12.
  - done=1 and busy=0 at edge 13 only.
  - Decoder output y steps 00000001 → 00000010 → 00000100 → 00001000, with 00000000 between steps.
- mode=1, dwell=1, last_idx=7, BLANK=1:
  - Index cycles 0..7 continuously, period 16 cycles.
  - wrap pulses on every return to a=0 (edges 17, 33, …), never on the first entry.
  - done stays 0.
- dwell=0, last_idx=0, mode=0:
  - Behaves as dwell=1: en=1 at edge 1, blank at edge 2, done at edge 3.
- stop asserted during the second cycle of index 2 (dwell=4):
  - Next edge: en=0, a=0, busy=0.
  - No done pulse.
  - A subsequent start restarts from a=0.
- Simultaneous events:
  - start+stop in IDLE → stays IDLE.
  - start while busy → no effect on the sequence.
  - Changing dwell/last_idx mid-sweep → sweep still uses the values latched at start.
- reset_n pulled low asynchronously mid-ACTIVE (between clock edges):
  - a=0, en=0, busy=0 immediately, before the next clk edge.
  - After release, stays IDLE until start.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer feeding an N-bit one-hot decoder.
// It steps index `a` from 0 to last_idx. Each index is held with `enable`
// high for D cycles, followed by BLANK cycles with `enable` low.
// It runs a single sweep or loops continuously. All outputs are registered.
module decoder_scan_sequencer #(
  parameter int N       = 3,
  parameter int DWELL_W = 8,
  parameter int BLANK   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N-1:0]       last_idx,
  output logic [N-1:0]       a,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

  localparam logic [DWELL_W-1:0] DONE_ONE = DWELL_W'(1);
  localparam logic [7:0]         BLANK_L  = 8'(BLANK);

  state_t             state, state_n;
  logic [N-1:0]       a_n, last_q, last_n;
  logic               en_n, busy_n, done_n, wrap_n, mode_q, mode_n;
  logic [DWELL_W-1:0] dcnt, dcnt_n, d_q, d_n;
  logic [7:0]         bcnt, bcnt_n;
  logic               adv;

  // State, outputs and sweep parameters latched at start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      a      <= '0;
      enable <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
      dcnt   <= '0;
      bcnt   <= '0;
      mode_q <= 1'b0;
      last_q <= '0;
      d_q    <= DONE_ONE;
    end else begin
      state  <= state_n;
      a      <= a_n;
      enable <= en_n;
      busy   <= busy_n;
      done   <= done_n;
      wrap   <= wrap_n;
      dcnt   <= dcnt_n;
      bcnt   <= bcnt_n;
      mode_q <= mode_n;
      last_q <= last_n;
      d_q    <= d_n;
    end
  end

  // Next state, next outputs, and the dwell and blank counters.
  // dcnt and bcnt count the cycles already spent in the phase, starting at 1.
  always_comb begin
    state_n = state;
    a_n     = a;
    en_n    = enable;
    busy_n  = busy;
    done_n  = 1'b0;
    wrap_n  = 1'b0;
    dcnt_n  = dcnt;
    bcnt_n  = bcnt;
    mode_n  = mode_q;
    last_n  = last_q;
    d_n     = d_q;
    adv     = 1'b0;

    case (state)
      S_IDLE: begin
        a_n    = '0;
        en_n   = 1'b0;
        busy_n = 1'b0;
        dcnt_n = '0;
        bcnt_n = '0;
        // When start and stop coincide, stop wins.
        if (start && !stop) begin
          state_n = S_ACTIVE;
          mode_n  = mode;
          last_n  = last_idx;
          d_n     = (dwell == '0) ? DONE_ONE : dwell;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          dcnt_n  = DONE_ONE;
        end
      end
      S_ACTIVE: begin
        if (dcnt == d_q) begin
          if (BLANK > 0) begin
            state_n = S_BLANK;
            en_n    = 1'b0;
            bcnt_n  = 8'd1;
          end else begin
            adv = 1'b1;
          end
        end else begin
          dcnt_n = dcnt + DONE_ONE;
        end
      end
      S_BLANK: begin
        if (bcnt == BLANK_L) adv = 1'b1;
        else                 bcnt_n = bcnt + 8'd1;
      end
      default: state_n = S_IDLE;
    endcase

    if (adv) begin
      if (a < last_q) begin
        a_n     = a + 1'b1;
        state_n = S_ACTIVE;
        en_n    = 1'b1;
        dcnt_n  = DONE_ONE;
      end else if (!mode_q) begin
        state_n = S_IDLE;
        a_n     = '0;
        en_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        dcnt_n  = '0;
        bcnt_n  = '0;
      end else begin
        a_n     = '0;
        state_n = S_ACTIVE;
        en_n    = 1'b1;
        wrap_n  = 1'b1;
        dcnt_n  = DONE_ONE;
      end
    end

    // An abort overrides any coincident advance, done or wrap.
    if (stop && state != S_IDLE) begin
      state_n = S_IDLE;
      a_n     = '0;
      en_n    = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      wrap_n  = 1'b0;
      dcnt_n  = '0;
      bcnt_n  = '0;
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench for decoder_scan_sequencer.
// The stimulus side expands each sweep into its expected per-cycle trace
// from the sweep parameters and queues it. The monitor pops one entry per
// cycle and compares it against the DUT outputs.
module tb_decoder_scan_sequencer;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int BL = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [N-1:0]  last_idx = '0;
  logic [N-1:0]  a;
  logic          enable, busy, done, wrap;

  typedef struct packed {
    logic [N-1:0] a;
    logic         en;
    logic         busy;
    logic         done;
    logic         wrap;
  } obs_t;

  obs_t expq[$];
  obs_t tr[$];
  int   n_chk = 0, n_fail = 0;
  localparam obs_t IDLE_O = '0;

  decoder_scan_sequencer #(.N(N), .DWELL_W(DW), .BLANK(BL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .dwell(dwell), .last_idx(last_idx), .a(a), .enable(enable), .busy(busy),
    .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(int ai, bit en, bit b, bit d, bit w);
    obs_t o;
    o.a = ai[N-1:0]; o.en = en; o.busy = b; o.done = d; o.wrap = w;
    return o;
  endfunction

  task automatic chk(string nm, obs_t g, obs_t e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got a=%0d en=%b busy=%b done=%b wrap=%b, want a=%0d en=%b busy=%b done=%b wrap=%b",
               nm, g.a, g.en, g.busy, g.done, g.wrap, e.a, e.en, e.busy, e.done, e.wrap);
    end
  endtask

  // Monitor: one expected entry per cycle while the scoreboard holds any.
  initial begin : mon
    obs_t e;
    forever begin
      @(posedge clk); #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("seq", {a, enable, busy, done, wrap}, e);
      end
    end
  end

  // Reference trace: per index, D enabled cycles and then BL blank cycles.
  // Repeat passes carry wrap on their first cycle.
  // A single sweep ends with one done cycle.
  task automatic build_trace(bit md, int d, int li, int passes);
    tr.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i <= li; i++)
        for (int c = 0; c < d + BL; c++)
          tr.push_back(mk(i, c < d, 1'b1, 1'b0, (p > 0) && (i == 0) && (c == 0)));
    if (!md) tr.push_back(mk(0, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic run_sweep(bit md, int dw, int li, int passes, int stop_at, bit noise);
    int d, len, endj;
    d = (dw == 0) ? 1 : dw;
    build_trace(md, d, li, md ? passes : 1);
    len  = tr.size();
    endj = md ? len : len - 1;
    if (stop_at > endj && md) stop_at = len;
    @(negedge clk);
    mode = md; dwell = DW'(dw); last_idx = N'(li); start = 1'b1; stop = 1'b0;
    expq.push_back(tr[0]);
    for (int j = 1; j <= endj; j++) begin
      @(negedge clk);
      if (noise) begin
        mode = 1'($urandom); dwell = DW'($urandom); last_idx = N'($urandom);
        start = tr[j-1].busy ? 1'($urandom) : 1'b0;
      end else begin
        start = 1'b0;
      end
      if (j == stop_at) begin
        stop = 1'b1;
        expq.push_back(IDLE_O);
        break;
      end
      stop = 1'b0;
      expq.push_back(tr[j]);
    end
  endtask

  // Idle cycles. A stop pulse in IDLE must have no effect.
  task automatic tail(int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'($urandom);
      expq.push_back(IDLE_O);
    end
    @(negedge clk); stop = 1'b0; expq.push_back(IDLE_O);
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (expq.size() > 0 && t < 2000) begin @(negedge clk); t++; end
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", expq.size());
    end
  endtask

  initial begin
    int md, dw, li, ps, sa, endj;
    #2;
    chk("reset_state", {a, enable, busy, done, wrap}, IDLE_O);
    @(negedge clk); reset_n = 1'b1;
    tail(2);

    run_sweep(1'b0, 2, 3, 1, 999, 1'b0); tail(2);   // basic single sweep
    run_sweep(1'b1, 1, 7, 3, 999, 1'b0); tail(2);   // continuous, full range
    run_sweep(1'b0, 0, 0, 1, 999, 1'b0); tail(2);   // dwell 0 acts as 1
    run_sweep(1'b0, 4, 7, 1, 12,  1'b0);            // abort in 2nd cycle of index 2
    run_sweep(1'b0, 1, 2, 1, 999, 1'b0); tail(2);   // restart after abort
    run_sweep(1'b1, 1, 0, 4, 999, 1'b0); tail(2);   // continuous, single index

    // start together with stop in IDLE must be ignored
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); start = 1'b1; stop = 1'b1; expq.push_back(IDLE_O);
    end
    tail(1);

    // mid-sweep input noise and ignored start
    run_sweep(1'b0, 3, 5, 1, 999, 1'b1); tail(2);
    run_sweep(1'b1, 2, 2, 2, 999, 1'b1); tail(2);

    for (int r = 0; r < 8; r++) begin
      md = int'($urandom_range(0, 1));
      dw = int'($urandom_range(0, 4));
      li = int'($urandom_range(0, 7));
      ps = int'($urandom_range(1, 2));
      endj = md ? ps * (li + 1) * (((dw == 0) ? 1 : dw) + BL)
                : (li + 1) * (((dw == 0) ? 1 : dw) + BL);
      sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, endj)) : 999;
      run_sweep(md[0], dw, li, ps, sa, 1'b1);
      tail(2);
    end

    drain();

    // Asynchronous reset between clock edges during an active sweep
    @(negedge clk); mode = 1'b1; dwell = 8'd3; last_idx = 3'd7; start = 1'b1; stop = 1'b0;
    @(negedge clk); start = 1'b0;
    chk("active_before_reset", {a, enable, busy, done, wrap}, mk(0, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", {a, enable, busy, done, wrap}, IDLE_O);
    @(negedge clk);
    chk("held_reset", {a, enable, busy, done, wrap}, IDLE_O);
    reset_n = 1'b1;
    tail(4);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
